// File: rtl/packet_requester.sv
// Packet buffer that requests arbitration for its head word; cut-through by default,
// store-and-forward when PACKET_REQUESTER_STORE_FWD_EN is defined.
module packet_requester #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       req,
    output logic                       req_is_last,
    input  logic                       grant,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    // Each entry holds {last, data}
    logic [DATA_W:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_level;
    logic [CW-1:0]     r_pkt_cnt;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_req;
    logic [DATA_W:0]   w_head;
    logic              w_head_last;
    logic              w_pkt_inc;
    logic              w_pkt_dec;

    assign w_full      = (r_level == FULL_LVL);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_last = w_head[DATA_W];

`ifdef PACKET_REQUESTER_STORE_FWD_EN
    // The full term lets a packet larger than the buffer drain instead of deadlocking
    assign w_req = (r_pkt_cnt != '0) | w_full;
`else
    assign w_req = (r_level != '0);
`endif

    assign w_push    = in_valid & ~w_full;
    assign w_pop     = w_req & grant;
    assign w_pkt_inc = w_push & in_last;
    assign w_pkt_dec = w_pop & w_head_last;

    assign in_ready    = ~w_full;
    assign req         = w_req;
    assign req_is_last = w_req & w_head_last;
    assign out_data    = w_head[DATA_W-1:0];
    assign level       = r_level;
    assign pkt_cnt     = r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + CNT_ONE;
                2'b01:   r_level <= r_level - CNT_ONE;
                default: r_level <= r_level;
            endcase
            case ({w_pkt_inc, w_pkt_dec})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_requester.sv
// Randomized bench for packet_requester against a queue-based model of the buffer;
// follows PACKET_REQUESTER_STORE_FWD_EN for the request rule.
module tb_packet_requester;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              req;
    logic              req_is_last;
    logic              grant;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     level;
    logic [CW-1:0]     pkt_cnt;

    packet_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .req        (req),
        .req_is_last(req_is_last),
        .grant      (grant),
        .out_data   (out_data),
        .level      (level),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    logic [DATA_W:0] q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (q[i]) if (q[i][DATA_W]) n++;
        return n;
    endfunction

    function automatic bit model_req();
`ifdef PACKET_REQUESTER_STORE_FWD_EN
        return (model_pkts() != 0) || (q.size() == DEPTH);
`else
        return q.size() != 0;
`endif
    endfunction

    task automatic check_state();
        bit r;
        logic [DATA_W:0] head;
        r = model_req();
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        check("req", 32'(req), 32'(r));
        check("level", 32'(level), 32'(q.size()));
        check("pkt_cnt", 32'(pkt_cnt), 32'(model_pkts()));
        if (r) begin
            head = q[0];
            check("out_data", 32'(out_data), 32'(head[DATA_W-1:0]));
            check("req_is_last", 32'(req_is_last), 32'(head[DATA_W]));
        end else begin
            check("req_is_last_idle", 32'(req_is_last), 32'(0));
        end
    endtask

    task automatic cycle(input bit v, input bit l, input logic [DATA_W-1:0] d, input bit g);
        bit push, pop;
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        grant    = g;
        #1;
        check_state();
        push = v && (q.size() != DEPTH);
        pop  = model_req() && g;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back({l, d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        grant    = 1'b0;
        q.delete();
        #1;
        check_state();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; grant = 1'b0;
        #12;
        do_reset();

        // Three-word packet with grant held; first push lands on first edge after reset
        cycle(1, 0, 8'hA1, 1);
        cycle(1, 0, 8'hA2, 1);
        cycle(1, 1, 8'hA3, 1);
        repeat (4) cycle(0, 0, 8'h00, 1);

        // Partial packet then its last word
        cycle(1, 0, 8'hB1, 0);
        cycle(1, 0, 8'hB2, 0);
        cycle(1, 1, 8'hB3, 0);
        repeat (2) cycle(0, 0, 8'h00, 0);
        repeat (4) cycle(0, 0, 8'h00, 1);

        // Fill without any last word, push against full, then drain
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 8'(8'h40 + i), 0);
        repeat (DEPTH + 2) cycle(0, 0, 8'h00, 1);

        // Simultaneous push and pop of one-word packets
        cycle(1, 1, 8'hC1, 0);
        cycle(1, 1, 8'hC2, 1);
        cycle(1, 1, 8'hC3, 1);
        repeat (3) cycle(0, 0, 8'h00, 1);

        // Pointers to 14, drain, then a packet straddling the wrap
        do_reset();
        for (int i = 0; i < 14; i++) cycle(1, (i == 13), 8'(8'h60 + i), 0);
        repeat (16) cycle(0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) cycle(1, (i == 4), 8'(8'hD0 + i), 0);
        repeat (7) cycle(0, 0, 8'h00, 1);

        // Asynchronous reset with words buffered and grant high
        for (int i = 0; i < 4; i++) cycle(1, (i == 1), 8'(8'hE0 + i), 0);
        @(negedge clk);
        in_valid = 1'b0;
        grant    = 1'b1;
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check_state();
        @(negedge clk);
        check_state();
        rst = 1'b0;
        repeat (2) cycle(0, 0, 8'h00, 1);

        // Randomized traffic with alternating grant-heavy and grant-light phases
        for (int i = 0; i < 1200; i++) begin
            bit v, l, g;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            if ((i / 64) % 2 == 0) g = ($urandom_range(0, 3) == 0);
            else                   g = ($urandom_range(0, 3) != 0);
            cycle(v, l, 8'($urandom), g);
        end
        repeat (DEPTH + 4) cycle(0, 0, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_requester.md
PACKET_REQUESTER -- requirements
Module: packet_requester

Interface
REQ-001 Parameter DATA_W, default 8: width of one packet word.
REQ-002 Parameter DEPTH, default 16: buffer capacity in words; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  DATA_W  upstream packet word.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_last  input  1  upstream word is the final word of its packet.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 req  output  1  request to the packet arbiter.
REQ-010 req_is_last  output  1  word offered with req is the final word of its packet.
REQ-011 grant  input  1  this requester's one-hot grant bit from the arbiter; same-cycle response to req.
REQ-012 out_data  output  DATA_W  head-of-buffer word, valid in any cycle where req is high.
REQ-013 level  output  $clog2(DEPTH)+1  words currently buffered.
REQ-014 pkt_cnt  output  $clog2(DEPTH)+1  complete packets currently buffered, counted by stored last words.

Function
REQ-015 Push = in_valid & in_ready; the block SHALL write {in_last, in_data} at the write pointer and increment the pointer, modulo DEPTH.
REQ-016 in_ready SHALL equal (level != DEPTH); a pop in the same cycle does not raise in_ready while full.
REQ-017 Pop = req & grant; the block SHALL advance the read pointer modulo DEPTH; grant while req is low SHALL be ignored.
REQ-018 out_data and the head last flag SHALL be combinational reads of the read-pointer entry: zero latency from buffer to arbiter.
REQ-019 req_is_last SHALL equal req & head last flag; req_is_last SHALL never be high while req is low.
REQ-020 level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 pkt_cnt: +1 on push with in_last, -1 on pop with head last flag, unchanged when both occur in the same cycle.
REQ-022 The block SHALL hold no FSM beyond the counters; req is a pure function of level, pkt_cnt and the configured mode.
REQ-023 Empty (level == 0): req SHALL be 0 and out_data is don't-care.
REQ-024 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; packets may straddle the wrap.
REQ-025 A word with in_last on a one-word packet SHALL be both first and last; pop of it decrements pkt_cnt.

Reset
REQ-026 On rst the block SHALL clear the read pointer, write pointer, level and pkt_cnt to 0; in_ready = 1, req = 0, req_is_last = 0.
REQ-027 rst mid-packet SHALL discard all buffered words, including partial packets; storage contents need not be cleared.
REQ-028 The first push after rst deasserts SHALL be accepted in the first clock edge with rst low.

Configuration
REQ-029 Macro PACKET_REQUESTER_STORE_FWD_EN selects store-and-forward mode.
REQ-030 When defined: req = (pkt_cnt != 0) | (level == DEPTH).
  - The full term lets an oversize packet drain in cut-through mode instead of deadlocking.
REQ-031 When undefined: req = (level != 0), i.e. cut-through; the arbiter may then hold a grant across upstream bubbles.

Verification
REQ-032 Reset, then push 3 words (last on word 3) with grant=1 held -> req rises after the first push; out_data pops in order; req_is_last=1 only on word 3; pkt_cnt ends at 0.
REQ-033 STORE_FWD_EN defined, push 2 of a 3-word packet -> req=0, level=2; push last word -> req=1 on the next cycle, pkt_cnt=1.
REQ-034 DEPTH=16, push 16 words with no last and grant=0 -> in_ready=0, level=16; in STORE_FWD_EN mode req=1 despite pkt_cnt=0.
REQ-035 Simultaneous push (in_last=1) and pop of a last word -> level and pkt_cnt unchanged; the read and write pointers both advance.
REQ-036 Fill to pointer 14, drain, then push a 5-word packet -> the packet straddles the wrap and pops intact in order.
REQ-037 Assert rst while 4 words are buffered and grant=1 -> level=0, pkt_cnt=0, req=0, in_ready=1 immediately and asynchronously; no further pops occur.
